// File: rtl/op2_pkg.sv
// op2_unit shared types: shift types, FSM states, amount classes.
// Classification helper used by the shifter front end.
package op2_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RSHIFT = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    AC_ZERO = 2'd0,
    AC_LT32 = 2'd1,
    AC_EQ32 = 2'd2,
    AC_GT32 = 2'd3
  } amt_cls_t;

  function automatic amt_cls_t classify(input logic [7:0] a);
    if (a == 8'd0)
      return AC_ZERO;
    else if (a < 8'd32)
      return AC_LT32;
    else if (a == 8'd32)
      return AC_EQ32;
    else
      return AC_GT32;
  endfunction

endpackage

// File: rtl/shift_carry_calc.sv
// Barrel shifter with ARM carry-out semantics.
// Amount class selects the edge-case behaviour; amt[4:0] the distance.
module shift_carry_calc
  import op2_pkg::*;
(
  input  shift_t      stype,
  input  logic [7:0]  amt,
  input  amt_cls_t    cls,
  input  logic [31:0] rm,
  input  logic        c_in,
  input  logic        rrx,
  output logic [31:0] res,
  output logic        c_out
);

  logic [4:0] a;
  logic [4:0] a_m1;
  logic [4:0] a_neg;
  logic [31:0] rot;
  logic [31:0] sgn;
  logic unused_amt;

  assign a = amt[4:0];
  assign a_m1 = a - 5'd1;
  assign a_neg = 5'd0 - a;
  assign rot = (rm >> a) | (rm << a_neg);
  assign sgn = {32{rm[31]}};
  assign unused_amt = ^amt[7:5];

  // result and carry selection by class then type
  always_comb begin
    res = rm;
    c_out = c_in;
    if (rrx) begin
      res = {c_in, rm[31:1]};
      c_out = rm[0];
    end else begin
      unique case (cls)
        AC_ZERO: begin
          res = rm;
          c_out = c_in;
        end
        AC_LT32: begin
          unique case (stype)
            SH_LSL: begin
              res = rm << a;
              c_out = rm[a_neg];
            end
            SH_LSR: begin
              res = rm >> a;
              c_out = rm[a_m1];
            end
            SH_ASR: begin
              res = $unsigned($signed(rm) >>> a);
              c_out = rm[a_m1];
            end
            SH_ROR: begin
              res = rot;
              c_out = rm[a_m1];
            end
          endcase
        end
        AC_EQ32: begin
          unique case (stype)
            SH_LSL: begin
              res = '0;
              c_out = rm[0];
            end
            SH_LSR: begin
              res = '0;
              c_out = rm[31];
            end
            SH_ASR: begin
              res = sgn;
              c_out = rm[31];
            end
            SH_ROR: begin
              res = rm;
              c_out = rm[31];
            end
          endcase
        end
        AC_GT32: begin
          unique case (stype)
            SH_LSL: begin
              res = '0;
              c_out = 1'b0;
            end
            SH_LSR: begin
              res = '0;
              c_out = 1'b0;
            end
            SH_ASR: begin
              res = sgn;
              c_out = rm[31];
            end
            SH_ROR: begin
              if (a == 5'd0) begin
                res = rm;
                c_out = rm[31];
              end else begin
                res = rot;
                c_out = rm[a_m1];
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/op2_unit.sv
// ARM data-processing operand-2 unit: FSM, capture and result regs.
// OP2_UNIT_REGSHIFT_EN enables shift-by-register via an RSHIFT cycle.
module op2_unit
  import op2_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        imm_flag,
  input  logic [11:0] op2_field,
  input  logic [31:0] rm_val,
  input  logic [31:0] rs_val,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op2,
  output logic        c_out
);

  state_t state, state_nx;
  logic accept;
  logic regsh;
  shift_t s_typ;
  logic [7:0] s_amt;
  amt_cls_t s_cls;
  logic [31:0] s_rm;
  logic s_cin;
  logic s_rrx;
  logic [31:0] res;
  logic res_c;
  logic [31:0] op2_q;
  logic c_q;

`ifdef OP2_UNIT_REGSHIFT_EN
  shift_t typ_q;
  logic [7:0] amt_q;
  amt_cls_t cls_q;
  logic [31:0] rm_q;
  logic cin_q;

  assign regsh = !imm_flag && op2_field[4];
`else
  logic unused_in;

  assign regsh = 1'b0;
  assign unused_in = ^{rs_val, op2_field[4]};
`endif

  assign accept = in_valid && in_ready;

  // shifter operand select: live decode or captured reg-shift request
  always_comb begin
    s_typ = shift_t'(op2_field[6:5]);
    s_amt = {3'b000, op2_field[11:7]};
    s_rm = rm_val;
    s_cin = c_in;
    s_rrx = 1'b0;
    if (imm_flag) begin
      s_typ = SH_ROR;
      s_amt = {3'b000, op2_field[11:8], 1'b0};
      s_rm = {24'd0, op2_field[7:0]};
    end else if (op2_field[11:7] == 5'd0) begin
      unique case (shift_t'(op2_field[6:5]))
        SH_LSL: s_amt = 8'd0;
        SH_LSR: s_amt = 8'd32;
        SH_ASR: s_amt = 8'd32;
        SH_ROR: s_rrx = 1'b1;
      endcase
    end
    s_cls = classify(s_amt);
`ifdef OP2_UNIT_REGSHIFT_EN
    if (state == S_RSHIFT) begin
      s_typ = typ_q;
      s_amt = amt_q;
      s_cls = cls_q;
      s_rm = rm_q;
      s_cin = cin_q;
      s_rrx = 1'b0;
    end
`endif
  end

  shift_carry_calc u_calc (
    .stype (s_typ),
    .amt   (s_amt),
    .cls   (s_cls),
    .rm    (s_rm),
    .c_in  (s_cin),
    .rrx   (s_rrx),
    .res   (res),
    .c_out (res_c)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (accept)
          state_nx = regsh ? S_RSHIFT : S_OUT;
`ifdef OP2_UNIT_REGSHIFT_EN
      S_RSHIFT:
        state_nx = S_OUT;
`endif
      S_OUT:
        if (out_ready)
          state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready = (state == S_IDLE);
    out_valid = (state == S_OUT);
  end

`ifdef OP2_UNIT_REGSHIFT_EN
  // capture reg-shift request and its amount class at accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      typ_q <= SH_LSL;
      amt_q <= '0;
      cls_q <= AC_ZERO;
      rm_q <= '0;
      cin_q <= 1'b0;
    end else if (accept && regsh) begin
      typ_q <= shift_t'(op2_field[6:5]);
      amt_q <= rs_val[7:0];
      cls_q <= classify(rs_val[7:0]);
      rm_q <= rm_val;
      cin_q <= c_in;
    end
  end
`endif

  // result register: loaded on single-cycle accept or leaving RSHIFT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op2_q <= '0;
      c_q <= 1'b0;
    end else if ((accept && !regsh) || state == S_RSHIFT) begin
      op2_q <= res;
      c_q <= res_c;
    end
  end

  assign op2 = op2_q;
  assign c_out = c_q;

endmodule

// File: tb/tb_op2_unit.sv
// Directed self-checking bench for op2_unit.
// Reg-shift scenarios compile in when OP2_UNIT_REGSHIFT_EN is defined.
module tb_op2_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic imm_flag = 1'b0;
  logic [11:0] op2_field = '0;
  logic [31:0] rm_val = '0;
  logic [31:0] rs_val = '0;
  logic c_in = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] op2;
  logic c_out;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  op2_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_flag  (imm_flag),
    .op2_field (op2_field),
    .rm_val    (rm_val),
    .rs_val    (rs_val),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op2       (op2),
    .c_out     (c_out)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // present one request, clock it in, then scramble the inputs
  task automatic issue(input logic i, input logic [11:0] f,
                       input logic [31:0] rm, input logic [31:0] rs,
                       input logic ci);
    imm_flag = i;
    op2_field = f;
    rm_val = rm;
    rs_val = rs;
    c_in = ci;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    rm_val = 32'hDEAD_BEEF;
    rs_val = 32'h0000_0007;
    c_in = ~ci;
    op2_field = 12'hFFF;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        op2 !== 32'd0 || c_out !== 1'b0) begin
      errs++;
      $display("FAIL reset: ov=%b ir=%b op2=%h c=%b want 0 1 0 0",
               out_valid, in_ready, op2, c_out);
    end
    #14;
    reset_n = 1'b1;
    cyc();
  endtask

  // one-cycle latency request: checks latency, value, carry
  task automatic run1(input string nm, input logic i,
                      input logic [11:0] f, input logic [31:0] rm,
                      input logic ci, input logic [31:0] eo,
                      input logic ec);
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s ready: in_ready=%b want 1", nm, in_ready);
    end
    issue(i, f, rm, 32'd0, ci);
    checks++;
    if (out_valid !== 1'b1 || op2 !== eo || c_out !== ec) begin
      errs++;
      $display("FAIL %s: ov=%b op2=%h c=%b want 1 %h %b",
               nm, out_valid, op2, c_out, eo, ec);
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s drain: ov=%b ir=%b want 0 1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_immediate();
    run1("imm_ff_r4", 1'b1, 12'h4FF, 32'h0, 1'b1, 32'hFF00_0000, 1'b1);
    run1("imm_r0_c0", 1'b1, 12'h05A, 32'h0, 1'b0, 32'h0000_005A, 1'b0);
    run1("imm_r0_c1", 1'b1, 12'h05A, 32'h0, 1'b1, 32'h0000_005A, 1'b1);
    run1("imm_81_r1", 1'b1, 12'h181, 32'h0, 1'b1, 32'h4000_0020, 1'b0);
  endtask

  task automatic test_shift_imm();
    run1("ror0_rrx", 1'b0, 12'h060, 32'h0000_0003, 1'b1,
         32'h8000_0001, 1'b1);
    run1("lsr0", 1'b0, 12'h020, 32'h8000_0000, 1'b0, 32'h0, 1'b1);
    run1("asr0", 1'b0, 12'h040, 32'h8000_0000, 1'b0,
         32'hFFFF_FFFF, 1'b1);
    run1("lsl0", 1'b0, 12'h000, 32'h0000_1234, 1'b1,
         32'h0000_1234, 1'b1);
    run1("lsl4", 1'b0, 12'h200, 32'hF000_000F, 1'b0,
         32'h0000_00F0, 1'b1);
    run1("lsr8", 1'b0, 12'h420, 32'h1234_5680, 1'b0,
         32'h0012_3456, 1'b1);
    run1("asr4", 1'b0, 12'h240, 32'h8000_0008, 1'b0,
         32'hF800_0000, 1'b1);
    run1("ror8", 1'b0, 12'h460, 32'h0000_00A5, 1'b0,
         32'hA500_0000, 1'b1);
    run1("lsr31", 1'b0, 12'hFA0, 32'h8000_0000, 1'b0,
         32'h0000_0001, 1'b0);
  endtask

`ifdef OP2_UNIT_REGSHIFT_EN
  // two-cycle latency request through RSHIFT
  task automatic run2(input string nm, input logic [11:0] f,
                      input logic [31:0] rm, input logic [31:0] rs,
                      input logic ci, input logic [31:0] eo,
                      input logic ec);
    issue(1'b0, f, rm, rs, ci);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL %s rshift: ov=%b ir=%b want 0 0",
               nm, out_valid, in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || op2 !== eo || c_out !== ec) begin
      errs++;
      $display("FAIL %s: ov=%b op2=%h c=%b want 1 %h %b",
               nm, out_valid, op2, c_out, eo, ec);
    end
    drain();
  endtask

  task automatic test_reg_shift();
    run2("rlsl32", 12'h010, 32'h1, 32'd32, 1'b0, 32'h0, 1'b1);
    run2("rlsl33", 12'h010, 32'h1, 32'd33, 1'b1, 32'h0, 1'b0);
    run2("rasrff", 12'h050, 32'h8000_0000, 32'h1FF, 1'b0,
         32'hFFFF_FFFF, 1'b1);
    run2("rror64", 12'h070, 32'h8000_0001, 32'd64, 1'b0,
         32'h8000_0001, 1'b1);
    run2("rlsr4", 12'h030, 32'h8000_0000, 32'd4, 1'b1,
         32'h0800_0000, 1'b0);
    run2("rror0", 12'h070, 32'h1234_5678, 32'h100, 1'b1,
         32'h1234_5678, 1'b1);
    run2("rlsl4", 12'h210, 32'hF000_000F, 32'd4, 1'b0,
         32'h0000_00F0, 1'b1);
  endtask
`else
  task automatic test_bit4_ignored();
    run1("bit4_lsl4", 1'b0, 12'h210, 32'hF000_000F, 1'b0,
         32'h0000_00F0, 1'b1);
  endtask
`endif

  task automatic test_backpressure();
    logic [31:0] held;
    issue(1'b0, 12'h200, 32'h0000_0011, 32'd0, 1'b0);
    held = 32'h0000_0110;
    in_valid = 1'b1;
    imm_flag = 1'b1;
    op2_field = 12'h0AA;
    c_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          op2 !== held || c_out !== 1'b0) begin
        errs++;
        $display("FAIL bp%0d: ov=%b ir=%b op2=%h c=%b want 1 0 %h 0",
                 k, out_valid, in_ready, op2, c_out, held);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op2 !== held) begin
      errs++;
      $display("FAIL bp_release: ov=%b ir=%b op2=%h want 0 1 %h",
               out_valid, in_ready, op2, held);
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || op2 !== 32'h0000_00AA || c_out !== 1'b1) begin
      errs++;
      $display("FAIL bp_second: ov=%b op2=%h c=%b want 1 000000aa 1",
               out_valid, op2, c_out);
    end
    drain();
  endtask

  task automatic reset_pulse(input string nm);
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        op2 !== 32'd0 || c_out !== 1'b0) begin
      errs++;
      $display("FAIL %s: ov=%b ir=%b op2=%h c=%b want 0 1 0 0",
               nm, out_valid, in_ready, op2, c_out);
    end
    #2;
    reset_n = 1'b1;
    cyc();
    cyc();
    checks++;
    if (out_valid !== 1'b0 || op2 !== 32'd0) begin
      errs++;
      $display("FAIL %s stale: ov=%b op2=%h want 0 0",
               nm, out_valid, op2);
    end
  endtask

  task automatic test_mid_reset();
    issue(1'b1, 12'h4FF, 32'h0, 32'd0, 1'b1);
    reset_pulse("rst_out");
`ifdef OP2_UNIT_REGSHIFT_EN
    issue(1'b0, 12'h010, 32'h1, 32'd32, 1'b1);
    reset_pulse("rst_rshift");
`endif
    run1("post_rst", 1'b1, 12'h0F0, 32'h0, 1'b0, 32'h0000_00F0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_shift_imm();
`ifdef OP2_UNIT_REGSHIFT_EN
    test_reg_shift();
`else
    test_bit4_ignored();
`endif
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/op2_unit.md
OP2_UNIT -- requirements
Module: op2_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid  in  1  request valid; in_ready  out  1  unit can accept; imm_flag  in  1  instruction I bit; op2_field  in  12  instruction bits [11:0].
REQ-003 SHALL have ports: rm_val  in  32  Rm operand; rs_val  in  32  Rs operand; c_in  in  1  current CPSR C.
REQ-004 SHALL have ports: out_valid  out  1  result valid; out_ready  in  1  consumer accepts; op2  out  32  shifted operand; c_out  out  1  shifter carry-out.

Function
REQ-005 SHALL use states IDLE, RSHIFT, OUT; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-006 SHALL capture imm_flag, op2_field, rm_val, rs_val, c_in on the edge where in_valid&&in_ready; later input changes have no effect.
REQ-007 SHALL transition IDLE->OUT on accept for immediate or shift-by-immediate forms (out_valid one cycle after accept).
REQ-008 SHALL transition IDLE->RSHIFT->OUT for shift-by-register (imm_flag=0, bit4=1); out_valid two cycles after accept.
REQ-009 SHALL hold op2, c_out, out_valid stable in OUT until out_ready=1; OUT->IDLE on out_valid&&out_ready; no new accept in the same cycle.
REQ-010 Immediate: op2 = imm8 rotated right by 2*rot4; c_out = c_in if rot4==0 else op2[31].
REQ-011 Shift by immediate (amt=bits[11:7], type=bits[6:5]): LSL #0 -> rm, c_in; LSR #0 -> 0, rm[31]; ASR #0 -> {32{rm[31]}}, rm[31]; ROR #0 -> RRX {c_in, rm[31:1]}, rm[0]; nonzero amounts per REQ-012.
REQ-012 Shift by register, amt = rs_val[7:0] (0..255): amt==0 -> rm, c_in for all types.
REQ-013 LSL: amt 1..31 -> rm<<amt, c=rm[32-amt]; 32 -> 0, c=rm[0]; >32 -> 0, c=0.
REQ-014 LSR: amt 1..31 -> rm>>amt, c=rm[amt-1]; 32 -> 0, c=rm[31]; >32 -> 0, c=0.
REQ-015 ASR: amt 1..31 -> arithmetic shift, c=rm[amt-1]; >=32 -> {32{rm[31]}}, c=rm[31].
REQ-016 ROR: amt[4:0]==0 with amt!=0 -> rm, c=rm[31]; else rotate by amt[4:0], c=rm[amt[4:0]-1].
REQ-017 RSHIFT cycle SHALL register the 8-bit amount classification (zero/<32/==32/>32); final result computed and registered on RSHIFT->OUT.

Reset
REQ-018 reset_n low SHALL force state IDLE, out_valid=0, op2=0, c_out=0, in_ready=1 immediately, including mid-operation (RSHIFT or OUT); pending request discarded.
REQ-019 After reset_n deasserts, the first accept SHALL occur no earlier than the next rising edge.

Configuration
REQ-020 Macro OP2_UNIT_REGSHIFT_EN defined: shift-by-register supported per REQ-008, REQ-012..017.
REQ-021 Macro undefined: RSHIFT state absent; bit4 ignored, every non-immediate request decoded as shift-by-immediate with one-cycle latency; rs_val unused.

Structure
REQ-022 Package op2_pkg SHALL hold shift-type enum (LSL=00, LSR=01, ASR=10, ROR=11), state enum, and amount-class enum.
REQ-023 Combinational sub-module shift_carry_calc SHALL compute result and carry from type, 8-bit amount, rm, c_in; op2_unit holds FSM and registers only.

Verification
REQ-024 Immediate imm8=0xFF rot4=4, c_in=1 -> op2=0xFF000000, c_out=1, out_valid one cycle after accept.
REQ-025 Shift-imm ROR #0, rm=0x00000003, c_in=1 -> op2=0x80000001, c_out=1; LSR #0 rm=0x80000000 -> op2=0, c_out=1.
REQ-026 Shift-reg LSL rs=32 rm=0x00000001 -> op2=0, c_out=1; rs=33 -> op2=0, c_out=0; out_valid two cycles after accept.
REQ-027 Shift-reg ASR rs=0x1FF (amt 0xFF) rm=0x80000000 -> op2=0xFFFFFFFF, c_out=1; ROR rs=64 rm=0x80000001 -> op2=0x80000001, c_out=1.
REQ-028 out_ready held 0 for 5 cycles with in_valid=1 -> op2/c_out stable, in_ready=0, no second accept until after handshake.
REQ-029 reset_n pulsed low during RSHIFT -> out_valid=0, op2=0, in_ready=1 immediately; no stale result after release.
